// File: rtl/paddle_motion_ctrl.sv
// Paddle kinematics: action code -> ramped velocity, reversal brake,
// field clamp; state advances once per frame_tick.
module paddle_motion_ctrl #(
    parameter logic [10:0] INIT_Y     = 11'd240,
    parameter logic [10:0] PAD_HEIGHT = 11'd80,
    parameter logic [10:0] FIELD_H    = 11'd480,
    parameter logic [10:0] MAX_SPEED  = 11'd8,
    parameter logic [10:0] ACCEL      = 11'd1,
    parameter logic [10:0] BRAKE      = 11'd2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [2:0]         action,
    output logic signed [10:0] paddle_posy,
    output logic signed [10:0] paddle_vely,
    output logic [1:0]         state,
    output logic               at_top,
    output logic               at_bottom
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam logic [10:0] HALF = PAD_HEIGHT >> 1;
    localparam logic [10:0] TOP  = FIELD_H - HALF;
    localparam logic signed [11:0] TOP_S = {1'b0, TOP};
    localparam logic signed [11:0] BOT_S = {1'b0, HALF};

    state_t             state_q;
    state_t             st_fsm;
    state_t             state_n;
    logic               dir_up;
    logic               dir_dn;
    logic               go;
    logic [10:0]        mag;
    logic [10:0]        mag_n;
    logic [11:0]        ramp;
    logic signed [11:0] vel12;
    logic signed [11:0] pos12;
    logic signed [10:0] posy_n;
    logic signed [10:0] vely_n;
    logic               top_n;
    logic               bot_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            paddle_posy <= INIT_Y;
            paddle_vely <= '0;
            at_top      <= 1'b0;
            at_bottom   <= 1'b0;
        end else if (frame_tick) begin
            state_q     <= state_n;
            paddle_posy <= posy_n;
            paddle_vely <= vely_n;
            at_top      <= top_n;
            at_bottom   <= bot_n;
        end
    end

    always_comb begin
        dir_up = (action == 3'd2);
        dir_dn = (action == 3'd3);
        go     = (state_q == UP) ? dir_up : dir_dn;
        mag    = paddle_vely[10] ? 11'(-paddle_vely) : 11'(paddle_vely);
        ramp   = {1'b0, mag} + {1'b0, ACCEL};
        st_fsm = state_q;
        mag_n  = mag;
        case (state_q)
            IDLE: begin
                if (dir_up) begin
                    st_fsm = UP;
                    mag_n  = ACCEL;
                end else if (dir_dn) begin
                    st_fsm = DOWN;
                    mag_n  = ACCEL;
                end else begin
                    mag_n  = '0;
                end
            end
            UP, DOWN: begin
                if (go) begin
                    mag_n = (ramp > {1'b0, MAX_SPEED}) ? MAX_SPEED : ramp[10:0];
                end else begin
                    // any non-driving code brakes; sign never flips here
                    mag_n = (mag > BRAKE) ? mag - BRAKE : '0;
                    if (mag_n == '0) st_fsm = IDLE;
                end
            end
            default: begin
                st_fsm = IDLE;
                mag_n  = '0;
            end
        endcase

        vel12 = {1'b0, mag_n};
        if (st_fsm == DOWN) vel12 = -vel12;
        pos12 = {paddle_posy[10], paddle_posy} + vel12;

        state_n = st_fsm;
        posy_n  = pos12[10:0];
        vely_n  = vel12[10:0];
        if (pos12 >= TOP_S) begin
            state_n = IDLE;
            posy_n  = TOP;
            vely_n  = '0;
        end else if (pos12 <= BOT_S) begin
            state_n = IDLE;
            posy_n  = HALF;
            vely_n  = '0;
        end
        top_n = (posy_n == TOP);
        bot_n = (posy_n == HALF);
    end

    always_comb begin
        state = state_q;
    end

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Directed bench for paddle_motion_ctrl with a queued expectation
// scoreboard fed by a frame-level reference model.
module tb_paddle_motion_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               frame_tick = 1'b0;
    logic [2:0]         action = 3'd0;
    logic signed [10:0] paddle_posy;
    logic signed [10:0] paddle_vely;
    logic [1:0]         state;
    logic               at_top;
    logic               at_bottom;

    paddle_motion_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .action     (action),
        .paddle_posy(paddle_posy),
        .paddle_vely(paddle_vely),
        .state      (state),
        .at_top     (at_top),
        .at_bottom  (at_bottom)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pos;
        int vel;
        int st;
        int top;
        int bot;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   m_pos = 240;
    int   m_vel = 0;
    int   m_st  = 0;

    int ramp_v[10]  = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};
    int brake_v[5]  = '{6, 4, 2, 0, -1};

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.pos = m_pos;
        e.vel = m_vel;
        e.st  = m_st;
        e.top = int'(m_pos == 440);
        e.bot = int'(m_pos == 40);
        sbq.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty expected=entry", tag);
            return;
        end
        e = sbq.pop_front();
        chk({tag, "_pos"}, int'(paddle_posy), e.pos);
        chk({tag, "_vel"}, int'(paddle_vely), e.vel);
        chk({tag, "_st"},  int'(state), e.st);
        chk({tag, "_top"}, int'(at_top), e.top);
        chk({tag, "_bot"}, int'(at_bottom), e.bot);
    endtask

    task automatic model_step(input logic [2:0] a);
        int d;
        int sgn;
        int m;
        int np;
        d = (a == 3'd2) ? 1 : (a == 3'd3) ? -1 : 0;
        if (m_st == 0) begin
            if (d != 0) begin
                m_vel = d;
                m_st  = (d > 0) ? 1 : 2;
            end else begin
                m_vel = 0;
            end
        end else begin
            sgn = (m_st == 1) ? 1 : -1;
            m   = (m_vel < 0) ? -m_vel : m_vel;
            if (d == sgn) begin
                m = (m + 1 > 8) ? 8 : m + 1;
            end else begin
                m = (m > 2) ? m - 2 : 0;
                if (m == 0) m_st = 0;
            end
            m_vel = sgn * m;
        end
        np = m_pos + m_vel;
        if (np >= 440) begin
            m_pos = 440; m_vel = 0; m_st = 0;
        end else if (np <= 40) begin
            m_pos = 40; m_vel = 0; m_st = 0;
        end else begin
            m_pos = np;
        end
    endtask

    task automatic tick(input logic [2:0] a, input string tag);
        model_step(a);
        push_model();
        frame_tick = 1'b1;
        action     = a;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        action     = 3'($urandom_range(0, 7));
        pop_cmp(tag);
    endtask

    task automatic gap(input int n, input string tag);
        push_model();
        repeat (n) begin
            action = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        pop_cmp(tag);
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        frame_tick = 1'b1;
        action     = 3'd2;
        m_pos = 240; m_vel = 0; m_st = 0;
        push_model();
        repeat (n) @(posedge clk);
        #1;
        rst        = 1'b0;
        frame_tick = 1'b0;
        pop_cmp("reset");
    endtask

    initial begin
        // reset held with tick active: no movement
        do_reset(2);
        gap(2, "post_reset");

        // ramp with idle gaps
        for (int i = 0; i < 10; i++) begin
            tick(3'd2, "ramp");
            chk("ramp_vel_tab", int'(paddle_vely), ramp_v[i]);
            if (i % 3 == 0) gap(3, "ramp_gap");
        end
        chk("ramp_pos_end", int'(paddle_posy), 292);
        chk("ramp_st_end", int'(state), 1);

        // brake then reverse
        do_reset(1);
        repeat (8) tick(3'd2, "pre_brake");
        for (int i = 0; i < 5; i++) begin
            tick(3'd3, "brake");
            chk("brake_vel_tab", int'(paddle_vely), brake_v[i]);
            if (i == 3) begin
                chk("brake_idle", int'(state), 0);
                chk("brake_pos", int'(paddle_posy), 288);
            end
        end
        chk("reverse_st", int'(state), 2);

        // top clamp
        do_reset(1);
        for (int i = 1; i <= 29; i++) begin
            tick(3'd2, "to_top");
            if (i == 28) begin
                chk("top28_pos", int'(paddle_posy), 436);
                chk("top28_vel", int'(paddle_vely), 8);
            end
        end
        chk("top29_pos", int'(paddle_posy), 440);
        chk("top29_vel", int'(paddle_vely), 0);
        chk("top29_st", int'(state), 0);
        chk("top29_flag", int'(at_top), 1);
        tick(3'd2, "push_top");
        chk("push_top_pos", int'(paddle_posy), 440);
        tick(3'd1, "hold_top");

        // bottom clamp
        do_reset(1);
        repeat (29) tick(3'd3, "to_bot");
        chk("bot_pos", int'(paddle_posy), 40);
        chk("bot_flag", int'(at_bottom), 1);
        tick(3'd3, "push_bot");

        // invalid codes behave as hold
        do_reset(1);
        repeat (4) tick(3'd2, "pre_inv");
        chk("inv_start_vel", int'(paddle_vely), 4);
        tick(3'd0, "inv0");
        chk("inv0_vel", int'(paddle_vely), 2);
        tick(3'd7, "inv7");
        chk("inv7_vel", int'(paddle_vely), 0);
        chk("inv7_st", int'(state), 0);

        // walk down to posy=100, vely=-5, then reset mid-motion
        do_reset(1);
        repeat (17) tick(3'd3, "walk_dn");
        repeat (4) tick(3'd1, "walk_brk");
        repeat (5) begin
            tick(3'd3, "step_dn");
            tick(3'd1, "step_hold");
        end
        repeat (5) tick(3'd3, "final_dn");
        chk("mid_pos", int'(paddle_posy), 100);
        chk("mid_vel", int'(paddle_vely), -5);
        rst        = 1'b1;
        frame_tick = 1'b1;
        action     = 3'd3;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        frame_tick = 1'b0;
        chk("midrst_pos", int'(paddle_posy), 240);
        chk("midrst_vel", int'(paddle_vely), 0);
        chk("midrst_st", int'(state), 0);
        m_pos = 240; m_vel = 0; m_st = 0;
        gap(2, "midrst_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
